// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Pulls one word at a time from an upstream FIFO and sends it on a serial
//   line. Frame: start bit (0), Data_width data bits LSB-first, optional even
//   parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//
//   Optional feature: define FIFO_SERIAL_TX_PARITY_EN to add the parity bit
//   (XOR of all data bits) between the last data bit and the stop bit.
//
// Parameters
//   Data_width    width of the FIFO word that is serialized
//   CLKS_PER_BIT  clk cycles per bit-time (2 .. 65535)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   tx_en       permits starting a new frame (looked at only while idle)
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   registered FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle read strobe
//   tx          serial line, idle high, registered
//   busy        high whenever a frame is in progress
//   frame_done  one-cycle pulse in the last cycle of the stop bit
module fifo_serial_tx #(
   parameter int Data_width   = 16,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [Data_width-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (Data_width > 1) ? $clog2(Data_width) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(Data_width - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
`ifdef FIFO_SERIAL_TX_PARITY_EN
      PAR   = 3'd6,
`endif
      STOP  = 3'd5
   } state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt, cnt_nxt, cnt_inc;
   logic [IW-1:0]         idx, idx_nxt;
   logic [Data_width-1:0] shreg, shreg_nxt;
   logic                  tx_nxt;
   logic                  bit_end;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic                  par_bit, par_nxt;
`endif

   assign bit_end = (cnt == CNT_LAST);
   assign cnt_inc = bit_end ? '0 : cnt + CW'(1);

   // All outputs are decodes of registered state, or registers themselves.
   assign fifo_rd_en = (state == RD);
   assign busy       = (state != IDLE);
   assign frame_done = (state == STOP) && bit_end;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         tx    <= 1'b1;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
         tx    <= tx_nxt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         par_bit <= par_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      idx_nxt   = idx;
      shreg_nxt = shreg;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_nxt   = par_bit;
`endif
      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (tx_en && !fifo_empty) state_nxt = RD;
         end
         RD: state_nxt = LOAD;
         LOAD: begin
            // fifo_data is valid now, one cycle after the strobe
            shreg_nxt = fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            par_nxt   = ^fifo_data;
`endif
            idx_nxt   = '0;
            state_nxt = START;
         end
         START: begin
            cnt_nxt = cnt_inc;
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            cnt_nxt = cnt_inc;
            if (bit_end) begin
               // next data bit is always presented at shreg[0]
               shreg_nxt = shreg >> 1;
               if (idx == IDX_LAST) begin
                  idx_nxt = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                  state_nxt = PAR;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end
         end
`ifdef FIFO_SERIAL_TX_PARITY_EN
         PAR: begin
            cnt_nxt = cnt_inc;
            if (bit_end) state_nxt = STOP;
         end
`endif
         STOP: begin
            cnt_nxt = cnt_inc;
            if (bit_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // tx is registered from the value the line must carry in the next state,
      // so it lines up cycle-exactly with the state register.
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
         PAR:     tx_nxt = par_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

endmodule
